// File: rtl/sent_rx_data_reg.sv
// SENT RX data register: unpacks a CRC-good fast-channel frame into one or two
// 12-bit words and writes them to the RX FIFO with a strobe handshake.
module sent_rx_data_reg #(
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk_rx,
    input  logic             reset_rx,
    input  logic [2:0]       load_bit,
    input  logic [15:0]      data_f1,
    input  logic [11:0]      data_f2,
    input  logic             frame_valid,
    input  logic             fifo_rx_full,
    output logic [11:0]      data_out,
    output logic             write_enable_rx,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {IDLE, WR0, GAP, WR1} state_t;

    localparam logic [2:0] GAP_LAST = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

    state_t           state_q, state_d;
    logic [11:0]      word0_q, word0_d;
    logic [11:0]      word1_q, word1_d;
    logic             two_q, two_d;
    logic [2:0]       gap_q, gap_d;
    logic [11:0]      last_q, last_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [11:0]      unp0, unp1;
    logic             unp_two;

    always_comb begin
        unp0    = data_f1[11:0];
        unp1    = '0;
        unp_two = 1'b0;
        case (load_bit)
            3'b001: begin
                unp1    = data_f2;
                unp_two = 1'b1;
            end
            3'b110: begin
                unp0    = data_f1[13:2];
                unp1    = {4'b0, data_f1[1:0], data_f2[5:0]};
                unp_two = 1'b1;
            end
            3'b111: begin
                unp0    = data_f1[15:4];
                unp1    = {4'b0, data_f1[3:0], data_f2[3:0]};
                unp_two = 1'b1;
            end
            default: ;
        endcase
    end

    // The strobe is combinational on fifo_rx_full so a write lands in the
    // first cycle after capture; data_out holds the last written word.
    always_comb begin
        state_d         = state_q;
        word0_d         = word0_q;
        word1_d         = word1_q;
        two_d           = two_q;
        gap_d           = gap_q;
        last_d          = last_q;
        ovf_d           = 1'b0;
        cnt_d           = cnt_q;
        write_enable_rx = 1'b0;
        data_out        = last_q;

        if (frame_valid && (state_q != IDLE)) begin
            ovf_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_valid && (load_bit != 3'b000)) begin
                    word0_d = unp0;
                    word1_d = unp1;
                    two_d   = unp_two;
                    state_d = WR0;
                end
            end
            WR0: begin
                if (!fifo_rx_full) begin
                    write_enable_rx = 1'b1;
                    data_out        = word0_q;
                    last_d          = word0_q;
                    if (!two_q)               state_d = IDLE;
                    else if (GAP_CYCLES == 0) state_d = WR1;
                    else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = WR1;
                else                   gap_d   = gap_q + 3'd1;
            end
            WR1: begin
                if (!fifo_rx_full) begin
                    write_enable_rx = 1'b1;
                    data_out        = word1_q;
                    last_d          = word1_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_rx or negedge reset_rx) begin
        if (!reset_rx) begin
            state_q <= IDLE;
            word0_q <= '0;
            word1_q <= '0;
            two_q   <= 1'b0;
            gap_q   <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            two_q   <= two_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign overflow   = ovf_q;
    assign drop_count = cnt_q;

endmodule

// File: tb/tb_sent_rx_data_reg.sv
// Bench for sent_rx_data_reg: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based transaction model.
module tb_sent_rx_data_reg;

    localparam int GAP = 1;

    logic        clk_rx = 1'b0;
    logic        reset_rx;
    logic [2:0]  load_bit;
    logic [15:0] data_f1;
    logic [11:0] data_f2;
    logic        frame_valid;
    logic        fifo_rx_full;
    logic [11:0] data_out;
    logic        write_enable_rx;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    always #5 clk_rx = ~clk_rx;

    sent_rx_data_reg #(.GAP_CYCLES(GAP), .CNT_W(8)) dut (
        .clk_rx          (clk_rx),
        .reset_rx        (reset_rx),
        .load_bit        (load_bit),
        .data_f1         (data_f1),
        .data_f2         (data_f2),
        .frame_valid     (frame_valid),
        .fifo_rx_full    (fifo_rx_full),
        .data_out        (data_out),
        .write_enable_rx (write_enable_rx),
        .busy            (busy),
        .overflow        (overflow),
        .drop_count      (drop_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Model: words of the frame still to be written, cycles left before the
    // next word may go out, last written word, pending overflow, drop total.
    logic [11:0] m_pend[$];
    int          m_gap;
    logic [11:0] m_last;
    logic        m_ovf;
    int          m_drops;

    logic        s_we, s_busy, s_ovf;
    logic [11:0] s_data;
    logic [7:0]  s_cnt;
    logic [11:0] wlog[$];

    task automatic model_clear();
        m_pend.delete();
        m_gap   = 0;
        m_last  = '0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic cycle(input logic fv, input logic [2:0] lb, input logic [15:0] f1,
                         input logic [11:0] f2, input logic full);
        logic        m_busy, m_we;
        logic [11:0] m_data;
        int          a, b;
        @(negedge clk_rx);
        frame_valid  = fv;
        load_bit     = lb;
        data_f1      = f1;
        data_f2      = f2;
        fifo_rx_full = full;
        #1;
        s_we   = write_enable_rx;
        s_data = data_out;
        s_busy = busy;
        s_ovf  = overflow;
        s_cnt  = drop_count;
        if (s_we) wlog.push_back(s_data);

        m_busy = (m_pend.size() != 0);
        m_we   = m_busy && (m_gap == 0) && !full;
        m_data = m_we ? m_pend[0] : m_last;
        check_eq("we", {31'b0, s_we}, {31'b0, m_we});
        check_eq("data_out", {20'b0, s_data}, {20'b0, m_data});
        check_eq("busy", {31'b0, s_busy}, {31'b0, m_busy});
        check_eq("overflow", {31'b0, s_ovf}, {31'b0, m_ovf});
        check_eq("drop_count", {24'b0, s_cnt}, m_drops);

        m_ovf = fv && m_busy;
        if (m_ovf && m_drops < 255) m_drops++;
        if (m_we) begin
            m_last = m_pend.pop_front();
            if (m_pend.size() != 0) m_gap = GAP;
        end else if (m_busy && m_gap > 0) begin
            m_gap--;
        end
        if (!m_busy && fv && lb != 3'd0) begin
            a = int'(f1);
            b = int'(f2);
            case (lb)
                3'd1: begin
                    m_pend.push_back(12'(a % 4096));
                    m_pend.push_back(12'(b));
                end
                3'd6: begin
                    m_pend.push_back(12'((a / 4) % 4096));
                    m_pend.push_back(12'((a % 4) * 64 + b % 64));
                end
                3'd7: begin
                    m_pend.push_back(12'((a / 16) % 4096));
                    m_pend.push_back(12'((a % 16) * 16 + b % 16));
                end
                default: m_pend.push_back(12'(a % 4096));
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
    endtask

    initial begin
        int base;
        reset_rx     = 1'b0;
        frame_valid  = 1'b0;
        load_bit     = 3'd0;
        data_f1      = '0;
        data_f2      = '0;
        fifo_rx_full = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_rx);
        @(negedge clk_rx);
        check_eq("rst_we", {31'b0, write_enable_rx}, 0);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_data", {20'b0, data_out}, 0);
        check_eq("rst_cnt", {24'b0, drop_count}, 0);
        reset_rx = 1'b1;
        idle(2);

        // Mode 001: ABC, one gap cycle, 123
        cycle(1'b1, 3'b001, 16'h0ABC, 12'h123, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        check_eq("t1_w0_we", {31'b0, s_we}, 1);
        check_eq("t1_w0", {20'b0, s_data}, 32'hABC);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        check_eq("t1_gap_we", {31'b0, s_we}, 0);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        check_eq("t1_w1", {20'b0, s_data}, 32'h123);
        check_eq("t1_w1_busy", {31'b0, s_busy}, 1);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        check_eq("t1_busy_after", {31'b0, s_busy}, 0);
        check_eq("t1_data_hold", {20'b0, s_data}, 32'h123);

        // Mode 110, then 111, then single-word 011
        cycle(1'b1, 3'b110, 16'h3FFD, 12'h02A, 1'b0);
        idle(4);
        check_eq("t2_w0", {20'b0, wlog[wlog.size()-2]}, 32'hFFF);
        check_eq("t2_w1", {20'b0, wlog[wlog.size()-1]}, 32'h06A);
        cycle(1'b1, 3'b111, 16'h1234, 12'h005, 1'b0);
        idle(4);
        check_eq("t3_w0", {20'b0, wlog[wlog.size()-2]}, 32'h123);
        check_eq("t3_w1", {20'b0, wlog[wlog.size()-1]}, 32'h045);
        base = wlog.size();
        cycle(1'b1, 3'b011, 16'hF456, 12'hFFF, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        check_eq("t3b_w", {20'b0, s_data}, 32'h456);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        check_eq("t3b_busy", {31'b0, s_busy}, 0);
        check_eq("t3b_count", wlog.size() - base, 1);

        // load_bit 000 is ignored
        cycle(1'b1, 3'b000, 16'h1111, 12'h111, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        check_eq("t0_busy", {31'b0, s_busy}, 0);
        check_eq("t0_ovf", {31'b0, s_ovf}, 0);

        // FIFO full before and between the words
        base = wlog.size();
        cycle(1'b1, 3'b001, 16'h0ABC, 12'h123, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b1);
        check_eq("t4_stall0", wlog.size() - base, 0);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b1);
        check_eq("t4_stall1", wlog.size() - base, 1);
        idle(3);
        check_eq("t4_count", wlog.size() - base, 2);
        check_eq("t4_w0", {20'b0, wlog[base]}, 32'hABC);
        check_eq("t4_w1", {20'b0, wlog[base+1]}, 32'h123);

        // Collision during GAP
        base = wlog.size();
        cycle(1'b1, 3'b001, 16'h0ABC, 12'h123, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        cycle(1'b1, 3'b111, 16'h5555, 12'h555, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        check_eq("t5_ovf", {31'b0, s_ovf}, 1);
        check_eq("t5_cnt", {24'b0, s_cnt}, 1);
        idle(3);
        check_eq("t5_count", wlog.size() - base, 2);
        check_eq("t5_w1", {20'b0, wlog[base+1]}, 32'h123);

        // Saturation of the drop counter
        cycle(1'b1, 3'b001, 16'h0ABC, 12'h123, 1'b1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 3'b001, 16'h0777, 12'h777, 1'b1);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b1);
        check_eq("t6_sat", {24'b0, s_cnt}, 32'hFF);
        idle(4);

        // Asynchronous reset in the middle of GAP
        base = wlog.size();
        cycle(1'b1, 3'b001, 16'h0DEF, 12'h321, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        @(negedge clk_rx);
        #1;
        reset_rx = 1'b0;
        #1;
        check_eq("t7_we", {31'b0, write_enable_rx}, 0);
        check_eq("t7_busy", {31'b0, busy}, 0);
        check_eq("t7_data", {20'b0, data_out}, 0);
        check_eq("t7_cnt", {24'b0, drop_count}, 0);
        model_clear();
        repeat (2) @(posedge clk_rx);
        @(negedge clk_rx);
        reset_rx = 1'b1;
        idle(4);
        check_eq("t7_no_w1", wlog.size() - base, 1);
        cycle(1'b1, 3'b001, 16'h0246, 12'h135, 1'b0);
        idle(4);
        check_eq("t7_post_w0", {20'b0, wlog[wlog.size()-2]}, 32'h246);
        check_eq("t7_post_w1", {20'b0, wlog[wlog.size()-1]}, 32'h135);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 25), 3'($urandom_range(0, 7)),
                  16'($urandom), 12'($urandom), ($urandom_range(0, 99) < 30));
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sent_rx_data_reg.md
Name: sent_rx_data_reg

Overview:
- Receive-side counterpart of the SENT TX data register.
- Takes a decoded fast-channel frame (data_f1/data_f2) from the SENT RX control block after a frame passes CRC. Unpacks it into one or two 12-bit words according to load_bit. Pushes those words into the RX FIFO with a write-enable pulse handshake.
- Sits between the RX nibble decoder/control block and the RX FIFO.

Parameters:
- GAP_CYCLES, 1, idle cycles with write_enable_rx low between two consecutive FIFO writes of the same frame (0..7).
- CNT_W, 8, width of the saturating dropped-frame counter.

Ports:
- clk_rx  input  1  RX clock; all state updates on the rising edge.
- reset_rx  input  1  asynchronous, active-low reset.
- load_bit  input  3  fast-channel format; the same encoding as the TX side.
- data_f1  input  16  fast channel 1 payload, right-aligned.
- data_f2  input  12  fast channel 2 payload, right-aligned.
- frame_valid  input  1  one-cycle pulse: data_f1/data_f2/load_bit valid and CRC-good.
- fifo_rx_full  input  1  RX FIFO full.
- data_out  output  12  word presented to the FIFO.
- write_enable_rx  output  1  one-cycle FIFO write strobe.
- busy  output  1  high while a captured frame still has words to write.
- overflow  output  1  one-cycle pulse when a frame is dropped.
- drop_count  output  CNT_W  saturating count of dropped frames.

Behaviour:
- Reset (reset_rx low, asynchronous): all outputs are 0, FSM returns to IDLE, and the holding registers are cleared. A frame in progress is discarded and not counted.
- FSM states: IDLE, WR0, GAP, WR1.
- Capture: in IDLE, frame_valid with load_bit != 000 does the following at that edge:
  - latches word0, word1 and a two_words flag;
  - moves to WR0;
  - raises busy.
- Capture is ignored when load_bit == 000: no write, no overflow.
- Unpacking, word0 / word1:
  - 001: f1[11:0] / f2[11:0]; two words.
  - 010, 011, 100, 101: f1[11:0]; one word.
  - 110: f1[13:2] / {4'b0, f1[1:0], f2[5:0]}; two words.
  - 111: f1[15:4] / {4'b0, f1[3:0], f2[3:0]}; two words.
  - Unused upper input bits are ignored.
- Write handshake:
  - In WR0/WR1, if fifo_rx_full is low, drive data_out = word and pulse write_enable_rx for exactly 1 cycle.
  - If fifo_rx_full is high, hold the state with write_enable_rx low and wait with no timeout.
  - data_out holds its value until the next write; it is not cleared after a write.
- Transitions:
  - WR0 after its write goes to GAP if two_words, else to IDLE.
  - GAP counts GAP_CYCLES cycles, then goes to WR1. With GAP_CYCLES = 0, WR0 goes directly to WR1.
  - WR1 after its write goes to IDLE.
- Latency: frame_valid at edge N gives the first write_enable_rx in the cycle after edge N, provided the FIFO is not full.
- busy:
  - Asserted from the capture edge until the edge that leaves WR0 (single word) or WR1.
  - Low in IDLE.
  - busy is registered state: it is still high in the cycle the final write_enable_rx is high.
- Frame collision: frame_valid while the state is not IDLE (including the final-write cycle) drops the new frame.
  - overflow pulses for 1 cycle.
  - drop_count increments, saturating at all-ones.
  - The frame in progress is unaffected.
- frame_valid held high for several cycles: only the first cycle in IDLE captures. Later high cycles while busy count as drops.
- fifo_rx_full changing mid-frame: word order is always preserved; word1 is never written before word0.

Test Plan:
- load_bit=001, f1=16'h0ABC, f2=12'h123, FIFO not full → write 12'hABC, then 1 gap cycle, then 12'h123; busy low after.
- load_bit=110, f1=16'h3FFD (f1[13:2]=12'hFFF, f1[1:0]=2'b01), f2=12'h02A → words 12'hFFF then 12'h06A.
- load_bit=111, f1=16'h1234, f2=12'h005 → words 12'h123 then 12'h045; load_bit=011, f1=16'hF456 → single word 12'h456, busy for 1 write.
- fifo_rx_full high for 5 cycles before and between the two words of mode 001 → no strobe while full; both words written in order once full drops.
- Second frame_valid during WR1/GAP → overflow pulse, drop_count 0→1, the original two words written intact; 256 drops with CNT_W=8 → drop_count stays 8'hFF.
- reset_rx low mid-GAP → outputs 0 immediately (asynchronous), no write of word1; a frame_valid after reset release → normal capture.
